// File: rtl/bit_serial_processor_p_if.sv
`default_nettype none
// ============================================================================
//  Module      : bit_serial_processor_p_if
//  Description : Handshake/data bundle for the bit-serial logic processor.
//                The master modport drives loads, execute and function
//                selects. The slave modport (the processor) returns the
//                register values, the hex codes and the status flags.
//  Revision    : 1.0 - initial release
// ============================================================================
interface bit_serial_processor_p_if #(
  parameter int WIDTH = 8
);
  logic                   load_a;
  logic                   load_b;
  logic                   execute;
  logic [WIDTH-1:0]       din;
  logic [2:0]             f;
  logic [1:0]             r;
  logic [WIDTH-1:0]       aval;
  logic [WIDTH-1:0]       bval;
  logic [7*WIDTH/4-1:0]   ahex;
  logic [7*WIDTH/4-1:0]   bhex;
  logic                   busy;
  logic                   done;

  modport master (
    output load_a, load_b, execute, din, f, r,
    input  aval, bval, ahex, bhex, busy, done
  );

  modport slave (
    input  load_a, load_b, execute, din, f, r,
    output aval, bval, ahex, bhex, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/bit_serial_processor_p.sv
`default_nettype none
// ============================================================================
//  Module      : bit_serial_processor_p
//  Description : Bit-serial logic processor. Two WIDTH-bit registers A and B
//                are combined STEP bits per clock by one of eight bitwise
//                functions. The result is routed back into A and/or B, so a
//                full pass takes WIDTH/STEP cycles. Busy/done status is
//                provided.
//                Optional feature macro BSP_HEX_EN builds per-nibble
//                active-low 7-segment decoders. Without it, all digits are
//                blank.
//  Revision    : 1.0 - initial release
// ============================================================================
module bit_serial_processor_p #(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) (
  input  wire logic                   clk,
  input  wire logic                   rst_n,
  bit_serial_processor_p_if.slave     bus
);

  localparam int c_NSTEPS = WIDTH / STEP;
  localparam int c_CW     = (c_NSTEPS > 1) ? $clog2(c_NSTEPS) : 1;
  localparam int c_DIGITS = WIDTH / 4;
  localparam logic [c_CW-1:0] c_LAST = c_CW'(c_NSTEPS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [c_CW-1:0]  r_cnt;
  logic             r_exec_q;
  logic             r_busy;
  logic             r_done;

  logic [STEP-1:0]  w_a;
  logic [STEP-1:0]  w_b;
  logic [STEP-1:0]  w_fn;
  logic [STEP-1:0]  w_new_a;
  logic [STEP-1:0]  w_new_b;
  logic [WIDTH-1:0] w_a_next;
  logic [WIDTH-1:0] w_b_next;
  logic             w_exec_rise;
  logic             w_load;

  assign w_a         = r_a[STEP-1:0];
  assign w_b         = r_b[STEP-1:0];
  assign w_exec_rise = bus.execute & ~r_exec_q;
  assign w_load      = bus.load_a | bus.load_b;

  // Per-step function and routing of the low STEP bits of A and B
  always_comb begin
    w_fn    = '0;
    w_new_a = w_a;
    w_new_b = w_b;
    case (bus.f)
      3'b000:  w_fn = w_a & w_b;
      3'b001:  w_fn = w_a | w_b;
      3'b010:  w_fn = w_a ^ w_b;
      3'b011:  w_fn = '1;
      3'b100:  w_fn = ~(w_a & w_b);
      3'b101:  w_fn = ~(w_a | w_b);
      3'b110:  w_fn = ~(w_a ^ w_b);
      default: w_fn = '0;
    endcase
    case (bus.r)
      2'b00:   begin w_new_a = w_a;  w_new_b = w_b;  end
      2'b01:   begin w_new_a = w_fn; w_new_b = w_b;  end
      2'b10:   begin w_new_a = w_a;  w_new_b = w_fn; end
      default: begin w_new_a = w_b;  w_new_b = w_a;  end
    endcase
  end

  // New bits enter at the top while the register shifts right. The shift
  // form also covers STEP == WIDTH, where no old bits survive.
  assign w_a_next = (WIDTH'(w_new_a) << (WIDTH - STEP)) | (r_a >> STEP);
  assign w_b_next = (WIDTH'(w_new_b) << (WIDTH - STEP)) | (r_b >> STEP);

  // Control FSM, operand registers, step counter and execute edge history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_cnt    <= '0;
      r_exec_q <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      // The history always follows the level, so a press that arrives
      // during a pass or together with a load is simply consumed.
      r_exec_q <= bus.execute;
      r_done   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_load) begin
            if (bus.load_a) r_a <= bus.din;
            if (bus.load_b) r_b <= bus.din;
          end else if (w_exec_rise) begin
            r_state <= S_SHIFT;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        S_SHIFT: begin
          r_a   <= w_a_next;
          r_b   <= w_b_next;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == c_LAST) begin
            r_state <= S_HOLD;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        S_HOLD: begin
          if (!bus.execute) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.aval = r_a;
  assign bus.bval = r_b;
  assign bus.busy = r_busy;
  assign bus.done = r_done;

`ifdef BSP_HEX_EN
  function automatic logic [6:0] f_hex7(input logic [3:0] n);
    case (n)
      4'h0: f_hex7 = 7'b1000000;
      4'h1: f_hex7 = 7'b1111001;
      4'h2: f_hex7 = 7'b0100100;
      4'h3: f_hex7 = 7'b0110000;
      4'h4: f_hex7 = 7'b0011001;
      4'h5: f_hex7 = 7'b0010010;
      4'h6: f_hex7 = 7'b0000010;
      4'h7: f_hex7 = 7'b1111000;
      4'h8: f_hex7 = 7'b0000000;
      4'h9: f_hex7 = 7'b0010000;
      4'hA: f_hex7 = 7'b0001000;
      4'hB: f_hex7 = 7'b0000011;
      4'hC: f_hex7 = 7'b1000110;
      4'hD: f_hex7 = 7'b0100001;
      4'hE: f_hex7 = 7'b0000110;
      default: f_hex7 = 7'b0001110;
    endcase
  endfunction

  logic [7*c_DIGITS-1:0] w_ahex;
  logic [7*c_DIGITS-1:0] w_bhex;

  for (genvar gi = 0; gi < c_DIGITS; gi++) begin : g_hex
    assign w_ahex[7*gi +: 7] = f_hex7(r_a[4*gi +: 4]);
    assign w_bhex[7*gi +: 7] = f_hex7(r_b[4*gi +: 4]);
  end

  assign bus.ahex = w_ahex;
  assign bus.bhex = w_bhex;
`else
  assign bus.ahex = '1;
  assign bus.bhex = '1;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bit_serial_processor_p.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bit_serial_processor_p
//  Description : Directed self-checking bench. It uses three processor
//                instances (8/1, 8/2, 16/4) on a shared clock and reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bit_serial_processor_p;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_pass   = 0;

`ifdef BSP_HEX_EN
  localparam logic [6:0] c_H0 = 7'b1000000;
  localparam logic [6:0] c_HD = 7'b0100001;
  localparam logic [6:0] c_H4 = 7'b0011001;
`else
  localparam logic [6:0] c_H0 = 7'b1111111;
  localparam logic [6:0] c_HD = 7'b1111111;
  localparam logic [6:0] c_H4 = 7'b1111111;
`endif

  bit_serial_processor_p_if #(.WIDTH(8))  b0 ();
  bit_serial_processor_p_if #(.WIDTH(8))  b1 ();
  bit_serial_processor_p_if #(.WIDTH(16)) b2 ();

  bit_serial_processor_p #(.WIDTH(8),  .STEP(1)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  bit_serial_processor_p #(.WIDTH(8),  .STEP(2)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  bit_serial_processor_p #(.WIDTH(16), .STEP(4)) u2 (.clk(clk), .rst_n(rst_n), .bus(b2));

  // Free-running clock
  always #5 clk = ~clk;

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++; if (b0.aval !== 8'h00) $display("FAIL reset_a: got %h expected 00", b0.aval); else n_pass++;
    n_checks++; if (b0.bval !== 8'h00) $display("FAIL reset_b: got %h expected 00", b0.bval); else n_pass++;
    n_checks++; if (b0.busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", b0.busy); else n_pass++;
    n_checks++; if (b0.done !== 1'b0) $display("FAIL reset_done: got %b expected 0", b0.done); else n_pass++;
    n_checks++; if (b0.ahex !== {2{c_H0}}) $display("FAIL reset_ahex8: got %b expected %b", b0.ahex, {2{c_H0}}); else n_pass++;
    n_checks++; if (b2.bhex !== {4{c_H0}}) $display("FAIL reset_bhex16: got %b expected %b", b2.bhex, {4{c_H0}}); else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_and_w8s1();
    int nb = 0, nd = 0, fd = 0;
    b0.load_a = 1'b1; b0.din = 8'h33;
    @(negedge clk);
    b0.load_a = 1'b0; b0.load_b = 1'b1; b0.din = 8'h55;
    @(negedge clk);
    b0.load_b = 1'b0;
    n_checks++; if (b0.aval !== 8'h33) $display("FAIL load_a: got %h expected 33", b0.aval); else n_pass++;
    n_checks++; if (b0.bval !== 8'h55) $display("FAIL load_b: got %h expected 55", b0.bval); else n_pass++;
    b0.f = 3'b000; b0.r = 2'b01; b0.execute = 1'b1;
    // Execute stays high well past the pass: only one pass may run
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (b0.busy) nb++;
      if (b0.done) begin nd++; if (fd == 0) fd = i; end
    end
    n_checks++; if (nb != 8) $display("FAIL and_busy_cycles: got %0d expected 8", nb); else n_pass++;
    n_checks++; if (fd != 9) $display("FAIL and_done_cycle: got %0d expected 9", fd); else n_pass++;
    n_checks++; if (nd != 1) $display("FAIL and_done_count: got %0d expected 1", nd); else n_pass++;
    n_checks++; if (b0.aval !== 8'h11) $display("FAIL and_result_a: got %h expected 11", b0.aval); else n_pass++;
    n_checks++; if (b0.bval !== 8'h55) $display("FAIL and_result_b: got %h expected 55", b0.bval); else n_pass++;
  endtask

  task automatic test_load_with_press();
    int nb = 0, nd = 0;
    b0.execute = 1'b0;
    @(negedge clk);
    b0.load_a = 1'b1; b0.din = 8'hA5; b0.execute = 1'b1;
    @(negedge clk);
    b0.load_a = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (b0.busy) nb++;
      if (b0.done) nd++;
    end
    n_checks++; if (b0.aval !== 8'hA5) $display("FAIL loadpress_a: got %h expected a5", b0.aval); else n_pass++;
    n_checks++; if (nb != 0) $display("FAIL loadpress_busy: got %0d expected 0", nb); else n_pass++;
    n_checks++; if (nd != 0) $display("FAIL loadpress_done: got %0d expected 0", nd); else n_pass++;
    b0.execute = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_xor_w8s2();
    int nb = 0, fd = 0;
    b1.load_a = 1'b1; b1.load_b = 1'b1; b1.din = 8'h3C;
    @(negedge clk);
    b1.load_b = 1'b0; b1.din = 8'hF0;
    @(negedge clk);
    b1.load_a = 1'b0;
    n_checks++; if (b1.aval !== 8'hF0) $display("FAIL xor_load_a: got %h expected f0", b1.aval); else n_pass++;
    n_checks++; if (b1.bval !== 8'h3C) $display("FAIL xor_load_b: got %h expected 3c", b1.bval); else n_pass++;
    b1.f = 3'b010; b1.r = 2'b10; b1.execute = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (b1.busy) nb++;
      if (b1.done && fd == 0) fd = i;
    end
    b1.execute = 1'b0;
    n_checks++; if (nb != 4) $display("FAIL xor_busy_cycles: got %0d expected 4", nb); else n_pass++;
    n_checks++; if (fd != 5) $display("FAIL xor_done_cycle: got %0d expected 5", fd); else n_pass++;
    n_checks++; if (b1.aval !== 8'hF0) $display("FAIL xor_result_a: got %h expected f0", b1.aval); else n_pass++;
    n_checks++; if (b1.bval !== 8'hCC) $display("FAIL xor_result_b: got %h expected cc", b1.bval); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_swap_w16s4();
    int nb = 0, fd = 0;
    b2.load_a = 1'b1; b2.din = 16'h1234;
    @(negedge clk);
    b2.load_a = 1'b0; b2.load_b = 1'b1; b2.din = 16'hABCD;
    @(negedge clk);
    b2.load_b = 1'b0;
    b2.f = 3'b101; b2.r = 2'b11; b2.execute = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (b2.busy) nb++;
      if (b2.done && fd == 0) fd = i;
    end
    b2.execute = 1'b0;
    n_checks++; if (nb != 4) $display("FAIL swap_busy_cycles: got %0d expected 4", nb); else n_pass++;
    n_checks++; if (fd != 5) $display("FAIL swap_done_cycle: got %0d expected 5", fd); else n_pass++;
    n_checks++; if (b2.aval !== 16'hABCD) $display("FAIL swap_a: got %h expected abcd", b2.aval); else n_pass++;
    n_checks++; if (b2.bval !== 16'h1234) $display("FAIL swap_b: got %h expected 1234", b2.bval); else n_pass++;
    n_checks++; if (b2.ahex[6:0] !== c_HD) $display("FAIL swap_ahex0: got %b expected %b", b2.ahex[6:0], c_HD); else n_pass++;
    n_checks++; if (b2.bhex[6:0] !== c_H4) $display("FAIL swap_bhex0: got %b expected %b", b2.bhex[6:0], c_H4); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_pass();
    int nd = 0, nb = 0;
    b0.load_a = 1'b1; b0.din = 8'hFF;
    @(negedge clk);
    b0.load_a = 1'b0; b0.load_b = 1'b1; b0.din = 8'h0F;
    @(negedge clk);
    b0.load_b = 1'b0;
    b0.f = 3'b000; b0.r = 2'b01; b0.execute = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (b0.busy !== 1'b1) $display("FAIL mid_busy_before_reset: got %b expected 1", b0.busy); else n_pass++;
    rst_n = 1'b0;
    b0.execute = 1'b0;
    #1;
    n_checks++; if (b0.aval !== 8'h00) $display("FAIL mid_reset_a: got %h expected 00", b0.aval); else n_pass++;
    n_checks++; if (b0.bval !== 8'h00) $display("FAIL mid_reset_b: got %h expected 00", b0.bval); else n_pass++;
    n_checks++; if (b0.busy !== 1'b0) $display("FAIL mid_reset_busy: got %b expected 0", b0.busy); else n_pass++;
    repeat (2) begin
      @(negedge clk);
      if (b0.done) nd++;
    end
    rst_n = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (b0.done) nd++;
      if (b0.busy) nb++;
    end
    n_checks++; if (nd != 0) $display("FAIL mid_no_done: got %0d expected 0", nd); else n_pass++;
    n_checks++; if (nb != 0) $display("FAIL mid_no_busy: got %0d expected 0", nb); else n_pass++;
    b0.load_a = 1'b1; b0.din = 8'h5A;
    @(negedge clk);
    b0.load_a = 1'b0;
    n_checks++; if (b0.aval !== 8'h5A) $display("FAIL post_reset_load: got %h expected 5a", b0.aval); else n_pass++;
    // A fresh pass with NAND routed into A: ~(5A & 00) = FF
    b0.f = 3'b100; b0.r = 2'b01; b0.execute = 1'b1;
    @(negedge clk);
    b0.execute = 1'b0;
    nb = 1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (b0.busy) nb++;
    end
    n_checks++; if (nb != 8) $display("FAIL post_reset_busy: got %0d expected 8", nb); else n_pass++;
    n_checks++; if (b0.aval !== 8'hFF) $display("FAIL post_reset_nand: got %h expected ff", b0.aval); else n_pass++;
  endtask

  initial begin
    b0.load_a = 1'b0; b0.load_b = 1'b0; b0.execute = 1'b0; b0.din = '0; b0.f = '0; b0.r = '0;
    b1.load_a = 1'b0; b1.load_b = 1'b0; b1.execute = 1'b0; b1.din = '0; b1.f = '0; b1.r = '0;
    b2.load_a = 1'b0; b2.load_b = 1'b0; b2.execute = 1'b0; b2.din = '0; b2.f = '0; b2.r = '0;
    test_reset();
    test_and_w8s1();
    test_load_with_press();
    test_xor_w8s2();
    test_swap_w16s4();
    test_reset_mid_pass();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bit_serial_processor_p.md
# bit_serial_processor_p

Parametrised bit-serial logic processor: two WIDTH-bit operand registers A and B, loaded from a shared data bus, combined by one of eight bitwise functions. The result is produced by shifting STEP bits per clock, so a full pass takes WIDTH/STEP cycles, and is routed back into A and/or B. It replaces the fixed 8-bit, 1-bit-per-cycle processor in the lab top level and adds busy/done status and an optional per-nibble hex display drive.

## Interface
- WIDTH, 8: operand width; multiple of 4, ≥4.
- STEP, 1: bits processed per clock; must divide WIDTH.
- Clk  input  1  system clock; all state changes on its rising edge.
- Reset  input  1  asynchronous, active-low reset.
- LoadA  input  1  active-high level; loads Din into A.
- LoadB  input  1  active-high level; loads Din into B.
- Execute  input  1  active-high level; a rising edge starts one pass.
- Din  input  WIDTH  load data.
- F  input  3  function select.
- R  input  2  routing select.
- Aval  output  WIDTH  current A register.
- Bval  output  WIDTH  current B register.
- AHex  output  7*WIDTH/4  active-low 7-segment codes for A; digit i occupies bits [7i+6:7i] and shows A[4i+3:4i].
- BHex  output  7*WIDTH/4  same for B.
- Busy  output  1  high while in SHIFT.
- Done  output  1  one-cycle pulse when a pass completes.

## Operation
- Functions, applied per bit to the STEP LSBs of A (a) and B (b):
  - 000 a&b, 001 a|b, 010 a^b, 011 all ones.
  - 100 ~(a&b), 101 ~(a|b), 110 ~(a^b), 111 all zeros.
- Each step, A <= {newA, A[WIDTH-1:STEP]} and B <= {newB, B[WIDTH-1:STEP]}, where (newA, newB) depends on R:
  - 00: (a, b).
  - 01: (f, b).
  - 10: (a, f).
  - 11: (b, a), i.e. swap.
- After WIDTH/STEP steps the result equals the parallel operation. F and R are sampled every step; changing them mid-pass is legal and affects only the remaining steps.
- FSM states:
  - IDLE: loads accepted. A registered Execute rising edge (Execute=1 now, 0 at previous edge) with no load active moves to SHIFT and clears the step counter.
  - SHIFT: one step per clock; loads ignored. After step WIDTH/STEP-1, go to HOLD.
  - HOLD: wait for Execute=0, then go to IDLE. Holding Execute high never triggers a second pass.
- Loads in IDLE: LoadA and LoadB may be asserted together; both registers take Din.
- Load and execute edge in the same cycle: the load is performed and the execute edge is discarded; a new press is required.
- Execute edges in SHIFT or HOLD are ignored, and the edge detector still tracks the level.

## Timing
- Reset, asynchronous, any time including mid-pass, forces:
  - A=0, B=0, state IDLE, step counter 0, edge-detect history 0.
  - Busy=0, Done=0.
  - Hex outputs as described under Configuration.
- Load: Aval/Bval show Din one cycle after the sampling edge.
- Execute: the edge detected at clock k gives SHIFT at cycles k+1 through k+WIDTH/STEP.
  - Busy is high for exactly WIDTH/STEP cycles.
  - Final A/B are visible from cycle k+WIDTH/STEP+1; Done is high in that cycle only.
- Minimum time from one Execute press to the next accepted press: WIDTH/STEP+2 cycles, with Execute low for at least 1 cycle.
- Hex outputs are combinational from the A/B registers; no extra latency.

## Configuration
- BSP_HEX_EN defined: hex decoders are compiled in. Each digit shows 0-F in standard active-low codes, e.g. 0 = 7'b1000000 and F = 7'b0001110.
- BSP_HEX_EN undefined: no decoders are built and every AHex/BHex digit is tied to 7'b1111111 (blank). All other behaviour is identical.

## Test plan
- WIDTH=8, STEP=1. Reset, then load A=0x33, B=0x55, F=000, R=01, press Execute:
  - Busy is high for 8 cycles, then Done pulses.
  - A=0x11, B=0x55.
- WIDTH=8, STEP=2. A=0xF0, B=0x3C, F=010, R=10: Busy is high for 4 cycles; B=0xCC, A=0xF0.
- WIDTH=16, STEP=4. A=0x1234, B=0xABCD, R=11, any F:
  - Busy is high for 4 cycles; A=0xABCD, B=0x1234.
  - With BSP_HEX_EN, AHex digit 0 = 7'b0100001 (d).
- Hold Execute high for 30 cycles after a pass: exactly one Done. Press again with LoadA asserted in the same cycle: A=Din, no pass starts.
- Assert Reset low mid-SHIFT (step 3 of 8): A=B=0, Busy=0, Done never pulses. After release, the FSM is in IDLE and accepts a new load.
